pcgen: RTL

Program-counter generator for the five-stage pipeline, directly upstream of the fetch stage. Owns the architectural fetch PC register and drives it to fetch, which presents it unchanged as the instruction-bus address. Advances sequentially, holds on back-end stall or pending instruction-bus response, and applies branch/jump redirects from execute. Redirects arriving while a bus transfer is outstanding are buffered so the bus address never changes mid-transfer.

---
 rtl/pcgen_if.sv | 37 +++
 rtl/pcgen.sv | 80 ++++++++
 2 files changed

// File: rtl/pcgen_if.sv
// Front-end PC bus between pcgen, fetch, hazard unit and execute. Trap ports exist only under PCGEN_TRAP_EN.
// Latency: none; this is wiring only, and the latency is set by pcgen.
// Backpressure: imem_wait and stall are level signals sampled by pcgen every cycle.
interface pcgen_if;
    logic        imem_wait;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef PCGEN_TRAP_EN
    logic        trap_valid;
    logic [63:0] trap_pc;
`endif
    logic [63:0] pc;
    logic        drop_fetch;
    logic        pending;

    // master is the PC generator; slave is the surrounding pipeline
`ifdef PCGEN_TRAP_EN
    modport master (
        input  imem_wait, stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
        output pc, drop_fetch, pending
    );
    modport slave (
        output imem_wait, stall, redirect_valid, redirect_pc, trap_valid, trap_pc,
        input  pc, drop_fetch, pending
    );
`else
    modport master (
        input  imem_wait, stall, redirect_valid, redirect_pc,
        output pc, drop_fetch, pending
    );
    modport slave (
        output imem_wait, stall, redirect_valid, redirect_pc,
        input  pc, drop_fetch, pending
    );
`endif
endinterface

// File: rtl/pcgen.sv
// Fetch PC generator with redirect buffering. PCGEN_TRAP_EN adds trap ports, and a trap has priority over a redirect.
// Latency: 1 cycle from redirect to new pc when the bus is idle; otherwise 1 cycle after imem_wait drops.
// Backpressure: pc is held while imem_wait or stall is high, and a redirect during imem_wait is buffered in PEND.
module pcgen #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic      clk,
    input  logic      reset,
    pcgen_if.master   bus
);
    typedef enum logic {RUN, PEND} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic        tgt_vld;
    logic [63:0] tgt_pc;
    logic        advance;

    always_comb begin
        tgt_vld = bus.redirect_valid;
        tgt_pc  = bus.redirect_pc;
`ifdef PCGEN_TRAP_EN
        // A trap outranks a same-cycle branch redirect everywhere.
        if (bus.trap_valid) begin
            tgt_vld = 1'b1;
            tgt_pc  = bus.trap_pc;
        end
`endif
    end

    assign advance = ~bus.imem_wait & ~bus.stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            RUN: begin
                if (tgt_vld) begin
                    if (!bus.imem_wait) begin
                        // A redirect flushes the front end, so stall does not hold it back.
                        pc_d = tgt_pc;
                    end else begin
                        pend_pc_d = tgt_pc;
                        state_d   = PEND;
                    end
                end else if (advance) begin
                    pc_d = pc_q + 64'(INSTR_BYTES);
                end
            end
            PEND: begin
                if (bus.imem_wait) begin
                    if (tgt_vld) pend_pc_d = tgt_pc;
                end else begin
                    pc_d    = tgt_vld ? tgt_pc : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.drop_fetch = tgt_vld | (state_q == PEND);
    assign bus.pending    = (state_q == PEND);
endmodule
